// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-level UART transmit engine
// between N_REQ requesters. A requester keeps the engine until its
// end-of-message byte has been sent, so messages never interleave.
// A lock whose holder stops presenting data is released after
// HOLD_TIMEOUT cycles.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no lock; once the engine is free, pick the next requester
// LOAD    | locked; take the holder's next byte or count the hold time
// START   | one-cycle start pulse to the engine
// WAIT_HI | wait for the engine to report busy
// WAIT_LO | wait for the engine to finish; release after the last byte
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = 5208,
  parameter int TW           = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic               grant_valid,
  output logic [2:0]         grant_id,
  output logic               timeout_err
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TIMEOUT - 1);
  localparam logic [2:0] LAST_RESET = 3'(N_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t          state;
  logic [2:0]      last_id;
  logic            last_flag;
  logic [TW-1:0]   hold_cnt;

  logic [7:0]      data_arr [N_REQ];
  logic [IDXW-1:0] gidx;
  logic            win_found;
  logic [2:0]      win_id;
  logic [3:0]      cand;

  assign gidx = grant_id[IDXW-1:0];

  // Split the flat data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      data_arr[i] = req_data[8*i +: 8];
    end
  end

  // Round-robin scan starting just after the previous holder, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_id} + 4'(k);
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end
      if (!win_found && req_valid[cand[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[2:0];
      end
    end
  end

  // Lock/transfer sequencing; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_valid <= 1'b0;
      grant_id    <= 3'd0;
      timeout_err <= 1'b0;
      last_id     <= LAST_RESET;
      last_flag   <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      tx_start    <= 1'b0;
      req_ready   <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          // The engine may still be finishing a byte started before a reset.
          if (!tx_busy && win_found) begin
            grant_id    <= win_id;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (req_valid[gidx]) begin
            req_ready[gidx] <= 1'b1;
            tx_data         <= data_arr[gidx];
            last_flag       <= req_last[gidx];
            hold_cnt        <= '0;
            state           <= START;
          end else if (hold_cnt == HOLD_LAST) begin
            // Holder went quiet mid-message: drop the lock and give it
            // lowest priority in the next scan.
            timeout_err <= 1'b1;
            grant_valid <= 1'b0;
            last_id     <= grant_id;
            hold_cnt    <= '0;
            state       <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        START: begin
          tx_start <= 1'b1;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (last_flag) begin
              grant_valid <= 1'b0;
              last_id     <= grant_id;
              state       <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one byte-level UART transmit engine (8N1, 50 MHz system clock) between N_REQ requesters.
- Each requester pushes bytes over a valid/ready handshake and marks the final byte of a message with `last`.
- The arbiter locks the engine to one requester until that requester's `last` byte has been sent, so messages never interleave.
- Sits between the application message sources and the UART send engine, whose `uart_tx` pin goes to the board.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_TIMEOUT, 5208, clock cycles a locked requester may leave `req_valid` low before the lock is forcibly released (5208 = one bit time at 9600 baud on 50 MHz).
- TW, 13, width of the hold-timeout counter; must satisfy 2^TW > HOLD_TIMEOUT.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester byte valid.
- req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  N_REQ  per-requester end-of-message flag, qualified by req_valid.
- req_ready  output  N_REQ  one-cycle accept strobe per requester.
- tx_start  output  1  one-cycle start pulse to the UART engine.
- tx_data  output  8  byte to the engine; registered, stable from tx_start until the engine drops tx_busy.
- tx_busy  input  1  engine busy; rises 1-2 cycles after tx_start and falls after the stop bit.
- grant_valid  output  1  high while a requester holds the lock.
- grant_id  output  3  index of the lock holder; meaningful only when grant_valid=1.
- timeout_err  output  1  one-cycle pulse when a lock is released by timeout.

Behaviour:
- Reset values: req_ready=0, tx_start=0, tx_data=8'h00, grant_valid=0, grant_id=0, timeout_err=0. Round-robin pointer last_id=N_REQ-1, so requester 0 has top priority after reset. State=IDLE.
- Async reset mid-transfer returns every register to its reset value immediately. The in-flight engine byte is not aborted by this block; after reset, IDLE waits for tx_busy=0 before arbitrating.
- IDLE:
  - Requires tx_busy=0.
  - Scan req_valid starting at (last_id+1) mod N_REQ, wrapping; the first set bit wins.
  - Register grant_id=winner and grant_valid=1, then go to LOAD. Arbitration takes 1 cycle.
  - With no valid request, stay in IDLE.
- LOAD:
  - If req_valid[grant_id]=1: pulse req_ready[grant_id] for exactly this cycle, latch tx_data and last_flag from the granted requester, clear the hold counter, go to START. Only the granted requester's req_ready may rise.
  - If req_valid[grant_id]=0: increment the hold counter.
  - When the counter reaches HOLD_TIMEOUT: pulse timeout_err, set grant_valid=0, set last_id=grant_id, go to IDLE.
- START: tx_start=1 for exactly one cycle, then go to WAIT_HI.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
- WAIT_LO: wait for tx_busy=0.
  - If last_flag=1: set grant_valid=0, set last_id=grant_id, go to IDLE.
  - Otherwise go back to LOAD for the next byte.
- Back-to-back bytes within a message are separated by at least 1 idle cycle between tx_busy falling and the next tx_start (WAIT_LO→LOAD→START).
- Requests from non-granted requesters are ignored while locked; their req_ready stays 0 and they must keep data stable while req_valid=1.
- A request that arrives in the same cycle a lock is released is considered in the next IDLE cycle; the just-released requester has lowest priority.
- tx_start and req_ready are never asserted in the same cycle.

Test Plan:
- Single byte: req_valid[0]=1, data 8'h55, last=1 → req_ready[0] pulses once, tx_start pulses once with tx_data=8'h55; grant_valid falls after the engine's tx_busy falls.
- Message lock: requester 2 sends 3 bytes 8'h41, 8'h42, 8'h43 (last on 8'h43) while requester 1 is continuously valid → engine receives 41, 42, 43 contiguously, then requester 1 is granted; grant_id sequence is 2, 1.
- Round-robin fairness: all 4 requesters continuously valid with single-byte messages → grant_id order 0, 1, 2, 3, 0; exactly one req_ready pulse per grant.
- Hold timeout: requester 3 sends byte 8'h10 with last=0, then drops valid → after 5208 cycles in LOAD, timeout_err pulses once, grant_valid=0, and the next grant goes to requester 0 if it is valid.
- Reset mid-message: assert rst_n=0 during WAIT_LO of byte 2 of a 4-byte message → all outputs return to reset values at once; after release, no tx_start until tx_busy=0, and requester 0 has priority.
- Bench engine model: tx_busy rises 1 cycle after tx_start, stays high for 10×5208 cycles; check no second tx_start occurs while tx_busy=1.
